// File: rtl/conv_seq_ctrl.sv
// Read sequencer for a stride-1, valid-padding 3-row convolution layer.
// Issues one image/kernel read pair per cycle and emits datapath markers aligned to the returning RAM data.
module conv_seq_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DIM_WIDTH  = 8,
  parameter int RD_LAT     = 1,
  parameter int DRAIN_CYC  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [DIM_WIDTH-1:0]  cfg_img_w,
  input  logic [DIM_WIDTH-1:0]  cfg_img_h,
  input  logic [DIM_WIDTH-1:0]  cfg_k_w,
  input  logic [ADDR_WIDTH-1:0] cfg_img_base,
  input  logic [ADDR_WIDTH-1:0] cfg_kern_base,
  input  logic [2:0]            cfg_mask,
  output logic                  img_rd,
  output logic [ADDR_WIDTH-1:0] img_addr,
  output logic                  kern_rd,
  output logic [ADDR_WIDTH-1:0] kern_addr,
  output logic                  start,
  output logic [2:0]            mask,
  output logic                  clr_k_col_cnt,
  output logic                  clr_col_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

  localparam int DRAIN_W = $clog2(RD_LAT + DRAIN_CYC + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LAT + DRAIN_CYC - 1);

  state_t                state_q, state_d;
  logic [DIM_WIDTH-1:0]  img_w_q, img_w_d;
  logic [DIM_WIDTH-1:0]  k_w_q, k_w_d;
  logic [DIM_WIDTH-1:0]  out_w_q, out_w_d;
  logic [DIM_WIDTH-1:0]  out_h_q, out_h_d;
  logic [ADDR_WIDTH-1:0] kern_base_q, kern_base_d;
  logic [2:0]            mask_cfg_q, mask_cfg_d;
  logic [DIM_WIDTH-1:0]  k_q, k_d;
  logic [DIM_WIDTH-1:0]  oc_q, oc_d;
  logic [DIM_WIDTH-1:0]  b_q, b_d;
  logic [ADDR_WIDTH-1:0] col_base_q, col_base_d;
  logic [ADDR_WIDTH-1:0] band_base_q, band_base_d;
  logic                  img_rd_q, img_rd_d;
  logic [ADDR_WIDTH-1:0] img_addr_q, img_addr_d;
  logic [ADDR_WIDTH-1:0] kern_addr_q, kern_addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cfg_err_q, cfg_err_d;
  logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;
  // Marker delay line entry: {start, clrk, clrc, mask[2:0]}
  logic [5:0]            dly_q [RD_LAT];
  logic [5:0]            dly_d [RD_LAT];

  logic cfg_illegal_s;
  logic last_k_s;
  logic last_oc_s;
  logic last_b_s;
  logic issue_s;

  assign cfg_illegal_s = (cfg_k_w == '0) || (cfg_k_w > cfg_img_w) || (cfg_img_h < DIM_WIDTH'(3));
  assign last_k_s      = (k_q == k_w_q - DIM_WIDTH'(1));
  assign last_oc_s     = (oc_q == out_w_q - DIM_WIDTH'(1));
  assign last_b_s      = (b_q == out_h_q - DIM_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    img_w_d     = img_w_q;
    k_w_d       = k_w_q;
    out_w_d     = out_w_q;
    out_h_d     = out_h_q;
    kern_base_d = kern_base_q;
    mask_cfg_d  = mask_cfg_q;
    k_d         = k_q;
    oc_d        = oc_q;
    b_d         = b_q;
    col_base_d  = col_base_q;
    band_base_d = band_base_q;
    busy_d      = busy_q;
    cfg_err_d   = cfg_err_q;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;
    issue_s     = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (go) begin
          img_w_d     = cfg_img_w;
          k_w_d       = cfg_k_w;
          out_w_d     = cfg_img_w - cfg_k_w + DIM_WIDTH'(1);
          out_h_d     = cfg_img_h - DIM_WIDTH'(2);
          kern_base_d = cfg_kern_base;
          mask_cfg_d  = cfg_mask;
          k_d         = '0;
          oc_d        = '0;
          b_d         = '0;
          col_base_d  = cfg_img_base;
          band_base_d = cfg_img_base;
          cfg_err_d   = cfg_illegal_s;
          if (cfg_illegal_s) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            issue_s = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Advance k fastest, then output column, then band; each band restarts one image row lower.
        if (!last_k_s) begin
          k_d     = k_q + DIM_WIDTH'(1);
          issue_s = 1'b1;
        end else if (!last_oc_s) begin
          k_d        = '0;
          oc_d       = oc_q + DIM_WIDTH'(1);
          col_base_d = col_base_q + ADDR_WIDTH'(1);
          issue_s    = 1'b1;
        end else if (!last_b_s) begin
          k_d         = '0;
          oc_d        = '0;
          b_d         = b_q + DIM_WIDTH'(1);
          band_base_d = band_base_q + ADDR_WIDTH'(img_w_q);
          col_base_d  = band_base_d;
          issue_s     = 1'b1;
        end else begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (issue_s) begin
      img_rd_d    = 1'b1;
      img_addr_d  = col_base_d + ADDR_WIDTH'(k_d);
      kern_addr_d = kern_base_d + ADDR_WIDTH'(k_d);
    end else begin
      img_rd_d    = 1'b0;
      img_addr_d  = '0;
      kern_addr_d = '0;
    end

    // Stage 0 captures the markers of the read currently on the address bus.
    dly_d[0] = {img_rd_q, img_rd_q & last_k_s, img_rd_q & last_k_s & last_oc_s,
                img_rd_q ? mask_cfg_q : 3'b000};
    for (int i = 1; i < RD_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  // State, counters, latched config and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      img_w_q     <= '0;
      k_w_q       <= '0;
      out_w_q     <= '0;
      out_h_q     <= '0;
      kern_base_q <= '0;
      mask_cfg_q  <= 3'b000;
      k_q         <= '0;
      oc_q        <= '0;
      b_q         <= '0;
      col_base_q  <= '0;
      band_base_q <= '0;
      img_rd_q    <= 1'b0;
      img_addr_q  <= '0;
      kern_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      drain_cnt_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dly_q[i] <= 6'b000000;
      end
    end else begin
      state_q     <= state_d;
      img_w_q     <= img_w_d;
      k_w_q       <= k_w_d;
      out_w_q     <= out_w_d;
      out_h_q     <= out_h_d;
      kern_base_q <= kern_base_d;
      mask_cfg_q  <= mask_cfg_d;
      k_q         <= k_d;
      oc_q        <= oc_d;
      b_q         <= b_d;
      col_base_q  <= col_base_d;
      band_base_q <= band_base_d;
      img_rd_q    <= img_rd_d;
      img_addr_q  <= img_addr_d;
      kern_addr_q <= kern_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      drain_cnt_q <= drain_cnt_d;
      for (int i = 0; i < RD_LAT; i++) begin
        dly_q[i] <= dly_d[i];
      end
    end
  end

  assign img_rd        = img_rd_q;
  assign kern_rd       = img_rd_q;
  assign img_addr      = img_addr_q;
  assign kern_addr     = kern_addr_q;
  assign start         = dly_q[RD_LAT-1][5];
  assign clr_k_col_cnt = dly_q[RD_LAT-1][4];
  assign clr_col_cnt   = dly_q[RD_LAT-1][3];
  assign mask          = dly_q[RD_LAT-1][2:0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: a per-cycle expectation table built from the loop-nest rules,
// compared against the DUT every cycle, plus literal checks from hand-worked examples.
module tb_conv_seq_ctrl;
  localparam int RD_LAT = 2;
  localparam int DC     = 8;
  localparam int AW     = 12;
  localparam int DW     = 8;
  localparam int MAXC   = 2048;

  logic clk, reset, go;
  logic [DW-1:0] cfg_img_w, cfg_img_h, cfg_k_w;
  logic [AW-1:0] cfg_img_base, cfg_kern_base;
  logic [2:0] cfg_mask;
  logic img_rd, kern_rd, start, clr_k_col_cnt, clr_col_cnt, busy, done, cfg_err;
  logic [AW-1:0] img_addr, kern_addr;
  logic [2:0] mask;

  conv_seq_ctrl #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW), .RD_LAT(RD_LAT), .DRAIN_CYC(DC)) dut (
    .clk(clk), .reset(reset), .go(go),
    .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h), .cfg_k_w(cfg_k_w),
    .cfg_img_base(cfg_img_base), .cfg_kern_base(cfg_kern_base), .cfg_mask(cfg_mask),
    .img_rd(img_rd), .img_addr(img_addr), .kern_rd(kern_rd), .kern_addr(kern_addr),
    .start(start), .mask(mask), .clr_k_col_cnt(clr_k_col_cnt), .clr_col_cnt(clr_col_cnt),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs indexed by observed cycle number
  bit            e_rd [MAXC];
  logic [AW-1:0] e_ia [MAXC];
  logic [AW-1:0] e_ka [MAXC];
  bit            e_st [MAXC];
  bit            e_ck [MAXC];
  bit            e_cc [MAXC];
  logic [2:0]    e_mk [MAXC];
  bit            e_busy [MAXC];
  bit            e_done [MAXC];
  bit            e_err [MAXC];

  int errors = 0;
  int checks = 0;
  int last_done = 0;
  int n_rd, n_st, n_ck, n_cc, n_done, done_at;
  logic [AW-1:0] addr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void clear_from(input int t);
    for (int i = t; i < MAXC; i++) begin
      e_rd[i] = 1'b0; e_ia[i] = '0; e_ka[i] = '0; e_st[i] = 1'b0; e_ck[i] = 1'b0;
      e_cc[i] = 1'b0; e_mk[i] = 3'b000; e_busy[i] = 1'b0; e_done[i] = 1'b0; e_err[i] = 1'b0;
    end
  endfunction

  // Expected behaviour of one accepted go issued during cycle c
  function automatic void launch(input int c, input int w, input int h, input int kw,
                                 input int ib, input int kb, input logic [2:0] mk);
    int n, t, s, ow, oh, dcyc;
    bit bad;
    bad = (kw == 0) || (kw > w) || (h < 3);
    for (int i = c + 1; i < MAXC; i++) e_err[i] = bad;
    if (bad) begin
      e_done[c+1] = 1'b1;
      last_done = c + 1;
      return;
    end
    ow = w - kw + 1;
    oh = h - 2;
    n = 0;
    for (int b = 0; b < oh; b++)
      for (int oc = 0; oc < ow; oc++)
        for (int k = 0; k < kw; k++) begin
          t = c + 1 + n;
          s = t + RD_LAT;
          e_rd[t] = 1'b1;
          e_ia[t] = AW'(ib + b * w + oc + k);
          e_ka[t] = AW'(kb + k);
          e_st[s] = 1'b1;
          e_ck[s] = (k == kw - 1);
          e_cc[s] = (k == kw - 1) && (oc == ow - 1);
          e_mk[s] = mk;
          n++;
        end
    dcyc = c + 1 + n + RD_LAT + DC;
    for (int i = c + 1; i < dcyc; i++) e_busy[i] = 1'b1;
    e_done[dcyc] = 1'b1;
    last_done = dcyc;
  endfunction

  // Per-cycle comparison and run statistics
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      check("ctrl", {21'd0, img_rd, kern_rd, start, clr_k_col_cnt, clr_col_cnt, mask, busy, done, cfg_err},
            {21'd0, e_rd[cyc], e_rd[cyc], e_st[cyc], e_ck[cyc], e_cc[cyc], e_mk[cyc],
             e_busy[cyc], e_done[cyc], e_err[cyc]});
      if (e_rd[cyc]) check("addr", {8'd0, img_addr, kern_addr}, {8'd0, e_ia[cyc], e_ka[cyc]});
      if (img_rd === 1'b1) begin
        n_rd++;
        addr_q.push_back(img_addr);
      end
      if (start === 1'b1) n_st++;
      if (clr_k_col_cnt === 1'b1) n_ck++;
      if (clr_col_cnt === 1'b1) n_cc++;
      if (done === 1'b1) begin
        n_done++;
        done_at = cyc;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_stats();
    n_rd = 0; n_st = 0; n_ck = 0; n_cc = 0; n_done = 0; done_at = -1;
    addr_q.delete();
  endtask

  task automatic set_cfg(input int w, input int h, input int kw, input int ib, input int kb,
                         input logic [2:0] mk);
    cfg_img_w = DW'(w); cfg_img_h = DW'(h); cfg_k_w = DW'(kw);
    cfg_img_base = AW'(ib); cfg_kern_base = AW'(kb); cfg_mask = mk;
  endtask

  task automatic do_go();
    go = 1'b1;
    if (!reset && cyc > last_done)
      launch(cyc, int'(cfg_img_w), int'(cfg_img_h), int'(cfg_k_w), int'(cfg_img_base),
             int'(cfg_kern_base), cfg_mask);
    step();
    go = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc <= last_done) step();
    step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    clear_from(cyc + 1);
    last_done = cyc + n - 1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  int g;
  logic [AW-1:0] exp1 [9];
  logic [AW-1:0] expw [5];

  initial begin
    exp1 = '{12'h100, 12'h101, 12'h102, 12'h101, 12'h102, 12'h103, 12'h102, 12'h103, 12'h104};
    expw = '{12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'h002};
    reset = 1'b1; go = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 3'b000);
    clear_from(0);
    step(); step(); step();
    reset = 1'b0;
    last_done = cyc;
    step();

    // 3x5 image, 3-wide kernel: one band of three outputs
    clr_stats();
    set_cfg(5, 3, 3, 12'h100, 12'h020, 3'b101);
    g = cyc;
    do_go();
    wait_idle();
    check("t1_reads", n_rd, 9);
    for (int i = 0; i < 9; i++) check("t1_addr_lit", {20'd0, addr_q[i]}, {20'd0, exp1[i]});
    check("t1_clrk", n_ck, 3);
    check("t1_clrc", n_cc, 1);
    check("t1_done_cyc", done_at, g + 1 + 9 + RD_LAT + DC);
    check("t1_done_cnt", n_done, 1);

    // 4x4 image, 2-wide kernel: two bands, second starts one row lower
    clr_stats();
    set_cfg(4, 4, 2, 12'h040, 12'h010, 3'b111);
    g = cyc;
    do_go();
    wait_idle();
    check("t2_reads", n_rd, 12);
    check("t2_band2_addr", {20'd0, addr_q[6]}, 32'h044);
    check("t2_clrk", n_ck, 6);
    check("t2_clrc", n_cc, 2);
    check("t2_done_cyc", done_at, g + 23);

    // Illegal configs: k_w=0, k_w>img_w, img_h<3
    for (int j = 0; j < 3; j++) begin
      clr_stats();
      if (j == 0) set_cfg(5, 3, 0, 12'h100, 12'h020, 3'b111);
      else if (j == 1) set_cfg(5, 3, 6, 12'h100, 12'h020, 3'b111);
      else set_cfg(5, 2, 2, 12'h100, 12'h020, 3'b111);
      g = cyc;
      do_go();
      wait_idle();
      check("ill_reads", n_rd, 0);
      check("ill_done_cyc", done_at, g + 1);
      check("ill_err", {31'd0, cfg_err}, 32'd1);
    end

    // Legal run clears cfg_err; extra go pulses and cfg changes mid-run are ignored
    clr_stats();
    set_cfg(6, 3, 2, 12'h200, 12'h030, 3'b010);
    g = cyc;
    do_go();
    step(); step(); step();
    set_cfg(3, 7, 1, 12'h555, 12'h0AA, 3'b101);
    do_go();
    while (cyc < g + 14) step();
    set_cfg(9, 9, 4, 12'h000, 12'h000, 3'b001);
    do_go();
    wait_idle();
    check("t5_err_clr", {31'd0, cfg_err}, 32'd0);
    check("t5_reads", n_rd, 10);
    check("t5_done_cnt", n_done, 1);
    check("t5_done_cyc", done_at, g + 21);

    // Reset in the middle of a run
    clr_stats();
    set_cfg(5, 4, 2, 12'h300, 12'h040, 3'b001);
    do_go();
    repeat (5) step();
    do_reset(1);
    clr_stats();
    repeat (12) step();
    check("rst_no_start", n_st, 0);
    check("rst_no_done", n_done, 0);
    clr_stats();
    g = cyc;
    do_go();
    wait_idle();
    check("rst_rerun_reads", n_rd, 16);
    check("rst_rerun_clrc", n_cc, 2);
    check("rst_rerun_done", done_at, g + 27);

    // Address wrap with a single-column kernel
    clr_stats();
    set_cfg(5, 3, 1, 12'hFFE, 12'h050, 3'b110);
    g = cyc;
    do_go();
    wait_idle();
    for (int i = 0; i < 5; i++) check("wrap_addr_lit", {20'd0, addr_q[i]}, {20'd0, expw[i]});
    check("wrap_clrk_all", n_ck, n_st);
    check("wrap_starts", n_st, 5);
    check("wrap_done", done_at, g + 16);

    // go coincident with reset is ignored
    clr_stats();
    set_cfg(5, 3, 3, 12'h100, 12'h020, 3'b111);
    go = 1'b1;
    do_reset(1);
    go = 1'b0;
    repeat (6) step();
    check("go_rst_reads", n_rd, 0);
    check("go_rst_done", n_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_seq_ctrl.md
# conv_seq_ctrl

Read sequencer feeding the convolution datapath directly upstream. It walks a packed image memory and a kernel memory for one stride-1, valid-padding 3-row convolution layer. Each image word holds three vertically adjacent 8-bit pixels (rows b, b+1, b+2 at one column); each kernel word holds one 3-tap kernel column. It issues one read pair per cycle and produces `start`, `mask`, `clr_k_col_cnt` and `clr_col_cnt` aligned to the returning RAM data, so they feed the datapath's `img_data`/`kern_data` stream cycle-for-cycle.

## Interface
- ADDR_WIDTH, 12, image/kernel memory address width
- DIM_WIDTH, 8, width of image dimension and kernel width fields
- RD_LAT, 1, read latency of both memories in cycles (≥1)
- DRAIN_CYC, 8, idle cycles after the last aligned `start` before `done`; covers datapath pipeline and max-pool flush
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- go  in  1  single-cycle pulse; launches a layer when idle
- cfg_img_w  in  DIM_WIDTH  image width in columns
- cfg_img_h  in  DIM_WIDTH  image height in rows
- cfg_k_w  in  DIM_WIDTH  kernel width in columns
- cfg_img_base  in  ADDR_WIDTH  image word base address
- cfg_kern_base  in  ADDR_WIDTH  kernel word base address
- cfg_mask  in  3  lane enable, passed to `mask`
- img_rd  out  1  image memory read strobe
- img_addr  out  ADDR_WIDTH  image memory address
- kern_rd  out  1  kernel memory read strobe
- kern_addr  out  ADDR_WIDTH  kernel memory address
- start  out  1  datapath stream-valid, aligned to read data
- mask  out  3  datapath lane mask, aligned to read data
- clr_k_col_cnt  out  1  last-kernel-column marker, aligned to read data
- clr_col_cnt  out  1  last-read-of-band marker, aligned to read data
- busy  out  1  high from accepted `go` until `done`
- done  out  1  one-cycle completion pulse
- cfg_err  out  1  sticky; set when an accepted `go` has an illegal config; cleared by the next accepted `go`

## Operation
- Derived values: out_w = img_w − k_w + 1, out_h = img_h − 2.
- Configuration is latched on an accepted `go`. Config input changes during a run have no effect.
- Illegal config: k_w = 0, k_w > img_w, or img_h < 3. The block sets `cfg_err`, issues no reads, and asserts `done` on the cycle after `go`.
- FSM states and transitions:
  - IDLE: on `go`, go to RUN (legal) or DONE (illegal).
  - RUN: after the final read, go to DRAIN.
  - DRAIN: count RD_LAT + DRAIN_CYC cycles, then go to DONE.
  - DONE: one cycle, then IDLE.
- `go` while not in IDLE is ignored.
- Loop nest in RUN, innermost first: k in 0..k_w−1, oc in 0..out_w−1, b in 0..out_h−1. Exactly one read pair per cycle with no bubbles.
- img_addr = img_base + b·img_w + oc + k. Address arithmetic is modulo 2^ADDR_WIDTH and wraps silently.
- kern_addr = kern_base + k.
- Raw markers, generated alongside the address:
  - start_raw = 1 for every read.
  - clrk_raw = (k == k_w−1).
  - clrc_raw = (k == k_w−1 and oc == out_w−1).
  - mask_raw = latched cfg_mask.
- Total reads = out_h · out_w · k_w. Total `clr_k_col_cnt` pulses = out_h · out_w. Total `clr_col_cnt` pulses = out_h.
- k_w = 1: `clr_k_col_cnt` is high on every `start` cycle.

## Timing
- `img_addr`, `kern_addr`, `img_rd`, `kern_rd` are registered. The first read appears the cycle after `go` is accepted.
- `start`, `mask`, `clr_k_col_cnt` and `clr_col_cnt` are the raw markers delayed by exactly RD_LAT cycles. For a read issued at cycle t, its markers are high at t+RD_LAT, when that read's data is on the RAM output.
- `busy` rises the cycle after an accepted `go` and falls on the `done` cycle.
- Legal-run latency: `done` = go + 1 + reads + RD_LAT + DRAIN_CYC.
- Reset values: all outputs 0, FSM in IDLE, all counters 0.
- Reset mid-run aborts the run. The cycle after reset, every output is 0 and the delay line is flushed, so no stale `start` or marker escapes. No `done` is produced for the aborted run.
- `go` coincident with `reset` is ignored.

## Test plan
- img_w=5, img_h=3, k_w=3, img_base=0x100, kern_base=0x20 -> 9 reads. img_addr = 0x100,101,102,101,102,103,102,103,104. kern_addr repeats 0x20,21,22. 3 `clr_k_col_cnt` pulses, 1 `clr_col_cnt` pulse on the last read. `done` at go+1+9+RD_LAT+DRAIN_CYC.
- RD_LAT=2, img_w=4, img_h=4, k_w=2 -> 12 reads. Each marker lags its address by exactly 2 cycles. `clr_col_cnt` appears at band ends (reads 6 and 12). Second band starts at base+4.
- Illegal configs (k_w=0; k_w=6 with img_w=5; img_h=2) -> no `img_rd`, `cfg_err`=1, `done` on go+1. A following legal `go` clears `cfg_err`.
- `reset` asserted mid-RUN -> next cycle all outputs 0, no further `start`, no `done`. A new `go` then runs a full correct sequence.
- `go` pulsed during RUN and DRAIN, and cfg inputs toggled mid-run -> sequence and read count unchanged. Exactly one `done`.
- img_base=0xFFE, img_w=5 (ADDR_WIDTH=12) -> addresses wrap to 0x000 onward. k_w=1 -> `clr_k_col_cnt` high on every `start`.
